// File: rtl/vga_fb_reader.sv
// vga_fb_reader: VGA timing generator that reads a 2x2-scaled RGB565 frame buffer
// and has a built-in colour-bar test mode.
module vga_fb_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int AW       = 17
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          test_pattern,
    output logic [AW-1:0] rd_addr,
    input  logic [15:0]   rd_data,
    output logic [4:0]    vga_r,
    output logic [5:0]    vga_g,
    output logic [4:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_de,
    output logic          frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR     = H_ACTIVE / 8;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW-1:0] line_base;
    logic          h_end, vis, hs_n, vs_n, sof, tp_q, tp_now;
    logic [15:0]   bar, bar_p1, bar_p2;
    logic [1:0]    de_p, hs_p, vs_p, fs_p, sel_p;

    // Raster position decode, sync windows and colour-bar lookup for the current counter
    always_comb begin
        h_end  = h_cnt == H_LAST;
        vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_n   = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_n   = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        sof    = (h_cnt == '0) && (v_cnt == '0);
        tp_now = sof ? test_pattern : tp_q;
        bar    = (h_cnt < HW'(BAR))     ? 16'hFFFF :
                 (h_cnt < HW'(2 * BAR)) ? 16'hFFE0 :
                 (h_cnt < HW'(3 * BAR)) ? 16'h07FF :
                 (h_cnt < HW'(4 * BAR)) ? 16'h07E0 :
                 (h_cnt < HW'(5 * BAR)) ? 16'hF81F :
                 (h_cnt < HW'(6 * BAR)) ? 16'hF800 :
                 (h_cnt < HW'(7 * BAR)) ? 16'h001F : 16'h0000;
    end

    // Horizontal and vertical raster counters
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end)
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    // Buffer addressing: each stored row feeds two display lines, each stored pixel two clocks
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            line_base <= '0;
            rd_addr   <= '0;
        end else begin
            line_base <= (v_cnt == '0) ? '0 :
                         (h_end && v_cnt[0] && (v_cnt[VW-1:1] < (VW-1)'(IMG_H))) ? line_base + AW'(IMG_W) :
                         line_base;
            if (vis)
                rd_addr <= line_base + AW'(h_cnt >> 1);
        end
    end

    // Delay line so control signals and bar colours meet the returning read data
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            de_p   <= '0;
            hs_p   <= '1;
            vs_p   <= '1;
            fs_p   <= '0;
            sel_p  <= '0;
            tp_q   <= 1'b0;
            bar_p1 <= '0;
            bar_p2 <= '0;
        end else begin
            de_p   <= {de_p[0], vis};
            hs_p   <= {hs_p[0], hs_n};
            vs_p   <= {vs_p[0], vs_n};
            fs_p   <= {fs_p[0], sof};
            sel_p  <= {sel_p[0], tp_now};
            tp_q   <= tp_now;
            bar_p1 <= bar;
            bar_p2 <= bar_p1;
        end
    end

    // Output registers: colour is forced to black outside the visible window
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            {vga_r, vga_g, vga_b} <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            {vga_r, vga_g, vga_b} <= de_p[1] ? (sel_p[1] ? bar_p2 : rd_data) : '0;
            vga_hs      <= hs_p[1];
            vga_vs      <= vs_p[1];
            vga_de      <= de_p[1];
            frame_start <= fs_p[1];
        end
    end
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: directed tests of timing, addressing, blanking, test mode and reset.
// The DUT runs with a reduced raster so whole frames fit a short run:
// 32x12 visible in 48x19 total, 16x6 buffer, 4-pixel colour bars.
module tb_vga_fb_reader;
    localparam int HT = 48;
    localparam int FR = 912;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        test_pattern = 1'b0;
    logic        mem_ones = 1'b0;
    logic [16:0] rd_addr;
    logic [15:0] rd_data = '0;
    logic [4:0]  vga_r;
    logic [5:0]  vga_g;
    logic [4:0]  vga_b;
    logic        vga_hs, vga_vs, vga_de, frame_start;
    logic [15:0] rgb;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    int checks = 0;
    int errors = 0;

    assign rgb = {vga_r, vga_g, vga_b};

    vga_fb_reader #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .IMG_W(16), .IMG_H(6), .AW(17)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .test_pattern(test_pattern),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .frame_start(frame_start)
    );

    always #5 pclk = ~pclk;

    // Frame buffer model: mem[a] = a[15:0] with one clock of latency
    always_ff @(posedge pclk) rd_data <= mem_ones ? 16'hFFFF : rd_addr[15:0];

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
    endtask

    // Measures sync/frame_start edges, counted in clocks after reset release
    task automatic run_timing(output int hs_f1, output int hs_f2, output int hs_lo,
                              output int vs_f1, output int vs_f2, output int vs_lo,
                              output int fs1, output int fs2, output int fs_n);
        logic hs_prev = 1'b1;
        logic vs_prev = 1'b1;
        hs_f1 = -1; hs_f2 = -1; hs_lo = -1;
        vs_f1 = -1; vs_f2 = -1; vs_lo = -1;
        fs1 = -1; fs2 = -1; fs_n = 0;
        for (int k = 1; k <= 1900; k++) begin
            @(posedge pclk); #1;
            if (hs_prev && !vga_hs) begin
                if (hs_f1 < 0) hs_f1 = k; else if (hs_f2 < 0) hs_f2 = k;
            end
            if (!hs_prev && vga_hs && hs_lo < 0) hs_lo = k - hs_f1;
            if (vs_prev && !vga_vs) begin
                if (vs_f1 < 0) vs_f1 = k; else if (vs_f2 < 0) vs_f2 = k;
            end
            if (!vs_prev && vga_vs && vs_lo < 0) vs_lo = k - vs_f1;
            if (frame_start) begin
                fs_n++;
                if (fs1 < 0) fs1 = k; else if (fs2 < 0) fs2 = k;
            end
            hs_prev = vga_hs;
            vs_prev = vga_vs;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        checks++; if (rgb !== 16'h0000) begin errors++; $display("FAIL reset_rgb: got %h expected 0000", rgb); end
        checks++; if (rd_addr !== 17'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rd_addr); end
        checks++; if ({vga_hs, vga_vs, vga_de, frame_start} !== 4'b1100) begin
            errors++; $display("FAIL reset_ctrl: got hs/vs/de/fs=%b expected 1100", {vga_hs, vga_vs, vga_de, frame_start});
        end
    endtask

    task automatic test_timing();
        int hf1, hf2, hlo, vf1, vf2, vlo, f1, f2, fn;
        do_reset();
        run_timing(hf1, hf2, hlo, vf1, vf2, vlo, f1, f2, fn);
        checks++; if (hf1 !== 39)       begin errors++; $display("FAIL hs_first_fall: got %0d expected 39", hf1); end
        checks++; if (hf2 - hf1 !== HT) begin errors++; $display("FAIL hs_period: got %0d expected %0d", hf2 - hf1, HT); end
        checks++; if (hlo !== 6)        begin errors++; $display("FAIL hs_low: got %0d expected 6", hlo); end
        checks++; if (vf1 !== 675)      begin errors++; $display("FAIL vs_first_fall: got %0d expected 675", vf1); end
        checks++; if (vf2 - vf1 !== FR) begin errors++; $display("FAIL vs_period: got %0d expected %0d", vf2 - vf1, FR); end
        checks++; if (vlo !== 96)       begin errors++; $display("FAIL vs_low: got %0d expected 96", vlo); end
        checks++; if (f1 !== 3)         begin errors++; $display("FAIL fs_first: got %0d expected 3", f1); end
        checks++; if (f2 - f1 !== FR)   begin errors++; $display("FAIL fs_period: got %0d expected %0d", f2 - f1, FR); end
        checks++; if (fn !== 3)         begin errors++; $display("FAIL fs_count: got %0d expected 3", fn); end
    endtask

    task automatic test_addressing();
        int p, x, y, bad;
        bad = 0;
        do_reset();
        for (int k = 1; k <= FR + 3; k++) begin
            @(posedge pclk); #1;
            p = k - 3;
            if (p >= 0 && p < FR) begin
                x = p % HT; y = p / HT;
                if (x < 32 && y < 12 && rgb !== 16'((y / 2) * 16 + x / 2)) bad++;
                if (x <= 1 && y <= 1) begin
                    checks++; if (rgb !== 16'h0000) begin errors++; $display("FAIL px_%0d_%0d: got %h expected 0000", x, y, rgb); end
                end
                if (x == 2 && y == 0) begin
                    checks++; if (rgb !== 16'h0001) begin errors++; $display("FAIL px_2_0: got %h expected 0001", rgb); end
                end
                if (x == 0 && y == 2) begin
                    checks++; if (rgb !== 16'h0010) begin errors++; $display("FAIL px_0_2: got %h expected 0010", rgb); end
                end
                if (x == 31 && y == 11) begin
                    checks++; if (rgb !== 16'h005F) begin errors++; $display("FAIL px_last: got %h expected 005F", rgb); end
                end
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL addr_frame: got %0d bad pixels expected 0", bad); end
    endtask

    task automatic test_blanking();
        int p, x, y, de_n, de_bad, blank_bad, data_bad;
        logic exp_de;
        de_n = 0; de_bad = 0; blank_bad = 0; data_bad = 0;
        mem_ones = 1'b1;
        do_reset();
        for (int k = 1; k <= FR + 2; k++) begin
            @(posedge pclk); #1;
            p = k - 3;
            exp_de = 1'b0;
            if (p >= 0) begin
                x = p % HT; y = p / HT;
                exp_de = (x < 32) && (y < 12);
            end
            if (vga_de !== exp_de) de_bad++;
            if (vga_de === 1'b1) de_n++;
            if (vga_de !== 1'b1 && rgb !== 16'h0000) blank_bad++;
            if (vga_de === 1'b1 && rgb !== 16'hFFFF) data_bad++;
        end
        mem_ones = 1'b0;
        checks++; if (de_n !== 384)    begin errors++; $display("FAIL de_count: got %0d expected 384", de_n); end
        checks++; if (de_bad !== 0)    begin errors++; $display("FAIL de_window: got %0d bad cycles expected 0", de_bad); end
        checks++; if (blank_bad !== 0) begin errors++; $display("FAIL blank_rgb: got %0d nonzero cycles expected 0", blank_bad); end
        checks++; if (data_bad !== 0)  begin errors++; $display("FAIL visible_data: got %0d bad pixels expected 0", data_bad); end
    endtask

    task automatic test_pattern_mode();
        int p, x, y, b0, b1, b7, ball;
        b0 = 0; b1 = 0; b7 = 0; ball = 0;
        test_pattern = 1'b1;
        do_reset();
        for (int k = 1; k <= FR + 3; k++) begin
            @(posedge pclk); #1;
            p = k - 3;
            if (p >= 0 && p < FR) begin
                x = p % HT; y = p / HT;
                if (x < 32 && y < 12) begin
                    if (x < 4 && rgb !== 16'hFFFF) b0++;
                    if (x == 4 && rgb !== 16'hFFE0) b1++;
                    if (x >= 28 && rgb !== 16'h0000) b7++;
                    if (rgb !== bars[x / 4]) ball++;
                end
            end
        end
        test_pattern = 1'b0;
        checks++; if (b0 !== 0)   begin errors++; $display("FAIL bar_white: got %0d bad pixels expected 0", b0); end
        checks++; if (b1 !== 0)   begin errors++; $display("FAIL bar_x4: got %0d bad pixels expected 0", b1); end
        checks++; if (b7 !== 0)   begin errors++; $display("FAIL bar_black: got %0d bad pixels expected 0", b7); end
        checks++; if (ball !== 0) begin errors++; $display("FAIL bar_all: got %0d bad pixels expected 0", ball); end
    endtask

    task automatic test_midframe_toggle();
        int p, q, f, x, y, bad0, bad1;
        bad0 = 0; bad1 = 0;
        test_pattern = 1'b0;
        do_reset();
        for (int k = 1; k <= 2 * FR + 3; k++) begin
            @(posedge pclk); #1;
            p = k - 3;
            if (p == 5 * HT) test_pattern = 1'b1;
            if (p >= 0 && p < 2 * FR) begin
                f = p / FR; q = p % FR;
                x = q % HT; y = q / HT;
                if (x < 32 && y < 12) begin
                    if (f == 0 && rgb !== 16'((y / 2) * 16 + x / 2)) bad0++;
                    if (f == 1 && rgb !== bars[x / 4]) bad1++;
                end
            end
        end
        test_pattern = 1'b0;
        checks++; if (bad0 !== 0) begin errors++; $display("FAIL toggle_frame0: got %0d bad pixels expected 0", bad0); end
        checks++; if (bad1 !== 0) begin errors++; $display("FAIL toggle_frame1: got %0d bad pixels expected 0", bad1); end
    endtask

    task automatic test_reset_midline();
        int hf1, hf2, hlo, vf1, vf2, vlo, f1, f2, fn;
        do_reset();
        repeat (404) @(posedge pclk);
        #1;
        checks++; if (vga_de !== 1'b1 || rgb !== 16'd72) begin
            errors++; $display("FAIL pre_reset_px: got de=%b rgb=%h expected de=1 rgb=0048", vga_de, rgb);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({rgb, vga_de, vga_hs, vga_vs, frame_start} !== {16'h0000, 4'b0110}) begin
            errors++; $display("FAIL async_reset: got rgb=%h de/hs/vs/fs=%b expected rgb=0000 0110", rgb, {vga_de, vga_hs, vga_vs, frame_start});
        end
        checks++; if (rd_addr !== 17'd0) begin errors++; $display("FAIL async_reset_addr: got %0d expected 0", rd_addr); end
        @(negedge pclk);
        rst_n = 1'b1;
        run_timing(hf1, hf2, hlo, vf1, vf2, vlo, f1, f2, fn);
        checks++; if (f1 !== 3)    begin errors++; $display("FAIL rst_fs_first: got %0d expected 3", f1); end
        checks++; if (hf1 !== 39)  begin errors++; $display("FAIL rst_hs_first: got %0d expected 39", hf1); end
        checks++; if (hlo !== 6)   begin errors++; $display("FAIL rst_hs_low: got %0d expected 6", hlo); end
        checks++; if (vf1 !== 675) begin errors++; $display("FAIL rst_vs_first: got %0d expected 675", vf1); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_addressing();
        test_blanking();
        test_pattern_mode();
        test_midframe_toggle();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
